uart_reg_bridge: RTL and testbench

- Sits on the MCU side of uart_mcu and is the other end of its byte streams.
- Consumes received bytes (from_uart_*), decodes fixed-format register command frames, and drives a simple register bus.
- Returns one response byte per frame on the transmit stream (to_uart_*).
- Gives the host PC register access to the TX board over the serial line.

---
 rtl/uart_bridge_pkg.sv | 25 ++
 rtl/uart_reg_bridge_if.sv | 35 +++
 rtl/uart_bridge_timer.sv | 28 ++
 rtl/uart_reg_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART register bridge.
// Optional build macro: UART_BRIDGE_CHKSUM_EN adds a trailing XOR checksum byte per frame.
package uart_bridge_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_WR  = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_RD  = 8'h5A;
    localparam logic [BYTE_W-1:0] RSP_ACK = 8'h06;
    localparam logic [BYTE_W-1:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef UART_BRIDGE_CHKSUM_EN
        GET_CSUM,
`endif
        DO_WR,
        DO_RD,
        WAIT_RD,
        SEND
    } state_t;

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Byte-stream and register-bus signals between the bridge and its neighbours.
interface uart_reg_bridge_if;

    logic [7:0] from_uart_data;
    logic       from_uart_error;
    logic       from_uart_valid;
    logic       from_uart_ready;
    logic [7:0] to_uart_data;
    logic       to_uart_error;
    logic       to_uart_valid;
    logic       to_uart_ready;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_rdvalid;

    // Bridge side
    modport master (
        input  from_uart_data, from_uart_error, from_uart_valid, to_uart_ready,
        input  reg_rdata, reg_rdvalid,
        output from_uart_ready, to_uart_data, to_uart_error, to_uart_valid,
        output reg_addr, reg_wdata, reg_wr, reg_rd
    );

    // UART and register-file side
    modport slave (
        output from_uart_data, from_uart_error, from_uart_valid, to_uart_ready,
        output reg_rdata, reg_rdvalid,
        input  from_uart_ready, to_uart_data, to_uart_error, to_uart_valid,
        input  reg_addr, reg_wdata, reg_wr, reg_rd
    );

endinterface

// File: rtl/uart_bridge_timer.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module uart_bridge_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             expired_c
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down to zero and hold there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// Decodes register command frames from the UART receive stream, drives the
// register bus and returns one response byte per frame.
// Optional build macro: UART_BRIDGE_CHKSUM_EN (trailing XOR checksum byte).
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 1000000,
    parameter int unsigned RD_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    uart_reg_bridge_if.master bus
);

    // Timers load N-1 so expiry lands after N cycles in the counting state
    localparam int unsigned BYTE_TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int unsigned RD_TW   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    state_t            state;
    logic              is_wr;
    logic              rx_ready;
    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] wdata;
    logic              wr;
    logic              rd;
`ifdef UART_BRIDGE_CHKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    logic accept_c;
    logic byte_run_c;
    logic byte_expired_c;
    logic rd_expired_c;

    assign accept_c = bus.from_uart_valid && rx_ready;

    // Inter-byte timer runs only while a frame is partially received
    always_comb begin
        byte_run_c = 1'b0;
        if ((state == GET_ADDR) || (state == GET_DATA)) byte_run_c = 1'b1;
`ifdef UART_BRIDGE_CHKSUM_EN
        if (state == GET_CSUM) byte_run_c = 1'b1;
`endif
    end

    uart_bridge_timer #(.WIDTH(BYTE_TW)) u_byte_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (accept_c),
        .load_value (BYTE_TW'(BYTE_TIMEOUT - 1)),
        .en         (byte_run_c),
        .expired_c  (byte_expired_c)
    );

    uart_bridge_timer #(.WIDTH(RD_TW)) u_rd_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (state == DO_RD),
        .load_value (RD_TW'(RD_TIMEOUT - 1)),
        .en         (state == WAIT_RD),
        .expired_c  (rd_expired_c)
    );

    // Frame decoder, bus sequencer and response holder
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            addr     <= '0;
            wdata    <= '0;
            wr       <= 1'b0;
            rd       <= 1'b0;
`ifdef UART_BRIDGE_CHKSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr <= 1'b0;
            rd <= 1'b0;
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept_c) begin
                        if (!bus.from_uart_error && (bus.from_uart_data == CMD_WR ||
                                                     bus.from_uart_data == CMD_RD)) begin
                            is_wr <= (bus.from_uart_data == CMD_WR);
                            state <= GET_ADDR;
`ifdef UART_BRIDGE_CHKSUM_EN
                            csum  <= bus.from_uart_data;
`endif
                        end else begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_NAK;
                            rx_ready <= 1'b0;
                        end
                    end
                end
                GET_ADDR: begin
                    if (accept_c) begin
                        if (bus.from_uart_error) begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_NAK;
                            rx_ready <= 1'b0;
                        end else begin
                            addr <= bus.from_uart_data;
`ifdef UART_BRIDGE_CHKSUM_EN
                            csum  <= csum ^ bus.from_uart_data;
                            state <= is_wr ? GET_DATA : GET_CSUM;
`else
                            if (is_wr) begin
                                state <= GET_DATA;
                            end else begin
                                state    <= DO_RD;
                                rd       <= 1'b1;
                                rx_ready <= 1'b0;
                            end
`endif
                        end
                    end else if (byte_expired_c) begin
                        state <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (accept_c) begin
                        if (bus.from_uart_error) begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_NAK;
                            rx_ready <= 1'b0;
                        end else begin
                            wdata <= bus.from_uart_data;
`ifdef UART_BRIDGE_CHKSUM_EN
                            csum  <= csum ^ bus.from_uart_data;
                            state <= GET_CSUM;
`else
                            state    <= DO_WR;
                            wr       <= 1'b1;
                            rx_ready <= 1'b0;
`endif
                        end
                    end else if (byte_expired_c) begin
                        state <= IDLE;
                    end
                end
`ifdef UART_BRIDGE_CHKSUM_EN
                GET_CSUM: begin
                    if (accept_c) begin
                        rx_ready <= 1'b0;
                        if (bus.from_uart_error || (bus.from_uart_data != csum)) begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_NAK;
                        end else if (is_wr) begin
                            state <= DO_WR;
                            wr    <= 1'b1;
                        end else begin
                            state <= DO_RD;
                            rd    <= 1'b1;
                        end
                    end else if (byte_expired_c) begin
                        state <= IDLE;
                    end
                end
`endif
                DO_WR: begin
                    state    <= SEND;
                    tx_valid <= 1'b1;
                    tx_data  <= RSP_ACK;
                end
                DO_RD: begin
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (bus.reg_rdvalid) begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= bus.reg_rdata;
                    end else if (rd_expired_c) begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_NAK;
                    end
                end
                SEND: begin
                    if (bus.to_uart_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.from_uart_ready = rx_ready;
    assign bus.to_uart_valid   = tx_valid;
    assign bus.to_uart_data    = tx_data;
    assign bus.to_uart_error   = 1'b0;
    assign bus.reg_addr        = addr;
    assign bus.reg_wdata       = wdata;
    assign bus.reg_wr          = wr;
    assign bus.reg_rd          = rd;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge; responses and writes are scoreboarded.
module tb_uart_reg_bridge;

    localparam int unsigned TB_BYTE_TO = 300;
    localparam int unsigned TB_RD_TO   = 255;
    localparam logic [7:0]  B_WR  = 8'hA5;
    localparam logic [7:0]  B_RD  = 8'h5A;
    localparam logic [7:0]  B_ACK = 8'h06;
    localparam logic [7:0]  B_NAK = 8'h15;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wr_count;
    int   rd_count;
    logic prev_wr;
    logic prev_rd;

    logic [7:0]  exp_rsp[$];
    logic [15:0] exp_wr[$];

    uart_reg_bridge_if bif();

    uart_reg_bridge #(
        .BYTE_TIMEOUT (TB_BYTE_TO),
        .RD_TIMEOUT   (TB_RD_TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    // Response scoreboard: a byte leaves when valid and ready meet
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset && bif.to_uart_valid && bif.to_uart_ready) begin
            checks++;
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got %02h exp none", bif.to_uart_data);
            end else begin
                e = exp_rsp.pop_front();
                if (bif.to_uart_data !== e) begin
                    errors++;
                    $display("FAIL rsp_data got %02h exp %02h", bif.to_uart_data, e);
                end
            end
        end
    end

    // Write-strobe scoreboard plus one-cycle strobe checks
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            if (bif.reg_wr) begin
                wr_count++;
                checks++;
                if (prev_wr) begin
                    errors++;
                    $display("FAIL wr_pulse got 2+ cycles exp 1");
                end
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr got %02h<=%02h exp none", bif.reg_addr, bif.reg_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    if ({bif.reg_addr, bif.reg_wdata} !== e) begin
                        errors++;
                        $display("FAIL wr_bus got %02h<=%02h exp %02h<=%02h",
                                 bif.reg_addr, bif.reg_wdata, e[15:8], e[7:0]);
                    end
                end
            end
            if (bif.reg_rd) begin
                rd_count++;
                if (prev_rd) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_pulse got 2+ cycles exp 1");
                end
            end
            prev_wr = bif.reg_wr;
            prev_rd = bif.reg_rd;
        end else begin
            prev_wr = 1'b0;
            prev_rd = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        int n = 0;
        @(negedge clk);
        bif.from_uart_data  = b;
        bif.from_uart_error = err;
        bif.from_uart_valid = 1'b1;
        while (!bif.from_uart_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bif.from_uart_ready) begin
            errors++;
            $display("FAIL rx_ready got 0 exp 1 (byte %02h)", b);
        end
        @(posedge clk);
        #1;
        bif.from_uart_valid = 1'b0;
        bif.from_uart_error = 1'b0;
    endtask

    task automatic send_wr_frame(input logic [7:0] a, input logic [7:0] d);
        send_byte(B_WR, 1'b0);
        send_byte(a, 1'b0);
        send_byte(d, 1'b0);
`ifdef UART_BRIDGE_CHKSUM_EN
        send_byte(B_WR ^ a ^ d, 1'b0);
`endif
    endtask

    task automatic send_rd_frame(input logic [7:0] a);
        send_byte(B_RD, 1'b0);
        send_byte(a, 1'b0);
`ifdef UART_BRIDGE_CHKSUM_EN
        send_byte(B_RD ^ a, 1'b0);
`endif
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_rsp.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d/%0d pending exp 0/0", name, exp_rsp.size(), exp_wr.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [28:0] got;
        got = {bif.from_uart_ready, bif.to_uart_valid, bif.to_uart_data, bif.to_uart_error,
               bif.reg_wr, bif.reg_rd, bif.reg_addr, bif.reg_wdata};
        checks++;
        if (got !== 29'd0) begin
            errors++;
            $display("FAIL %s got %08h exp 00000000", name, got);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.from_uart_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %b exp 1", bif.from_uart_ready);
        end
    endtask

    task automatic test_write;
        int n = 0;
        exp_wr.push_back({8'h10, 8'h3C});
        exp_rsp.push_back(B_ACK);
        send_wr_frame(8'h10, 8'h3C);
        do begin
            @(negedge clk);
            n++;
        end while (!bif.to_uart_valid && n < 20);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL wr_latency got %0d exp 2", n);
        end
        drain("write");
    endtask

    task automatic test_read;
        int n = 0;
        int r0;
        r0 = rd_count;
        exp_rsp.push_back(8'h99);
        send_rd_frame(8'h22);
        @(negedge clk);
        while (!bif.reg_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bif.reg_rd !== 1'b1 || bif.reg_addr !== 8'h22) begin
            errors++;
            $display("FAIL rd_strobe got rd=%b addr=%02h exp rd=1 addr=22", bif.reg_rd, bif.reg_addr);
        end
        repeat (3) @(negedge clk);
        bif.reg_rdata   = 8'h99;
        bif.reg_rdvalid = 1'b1;
        @(negedge clk);
        bif.reg_rdvalid = 1'b0;
        bif.reg_rdata   = 8'h00;
        drain("read");
        checks++;
        if (rd_count != r0 + 1) begin
            errors++;
            $display("FAIL rd_count got %0d exp %0d", rd_count - r0, 1);
        end
    endtask

    task automatic test_read_timeout;
        int n = 0;
        int r0;
        int w0;
        r0 = rd_count;
        w0 = wr_count;
        exp_rsp.push_back(B_NAK);
        bif.to_uart_ready = 1'b0;
        send_rd_frame(8'h22);
        @(negedge clk);
        while (!bif.reg_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!bif.to_uart_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 255 || n > 258) begin
            errors++;
            $display("FAIL rd_timeout_cycles got %0d exp 256", n);
        end
        bif.to_uart_ready = 1'b1;
        drain("rd_timeout");
        // Stray read-valid while idle must be ignored
        bif.reg_rdata   = 8'h77;
        bif.reg_rdvalid = 1'b1;
        repeat (3) @(negedge clk);
        bif.reg_rdvalid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (rd_count != r0 + 1 || wr_count != w0) begin
            errors++;
            $display("FAIL rd_timeout_strobes got rd=%0d wr=%0d exp rd=1 wr=0", rd_count - r0, wr_count - w0);
        end
    endtask

    task automatic test_bad_cmd;
        exp_rsp.push_back(B_NAK);
        send_byte(8'h77, 1'b0);
        drain("bad_cmd");
    endtask

    task automatic test_byte_timeout;
        int w0;
        w0 = wr_count;
        send_byte(B_WR, 1'b0);
        repeat (TB_BYTE_TO + 20) @(negedge clk);
        checks++;
        if (bif.to_uart_valid !== 1'b0 || wr_count != w0) begin
            errors++;
            $display("FAIL byte_timeout_silent got valid=%b wr=%0d exp valid=0 wr=0",
                     bif.to_uart_valid, wr_count - w0);
        end
        exp_wr.push_back({8'h01, 8'h02});
        exp_rsp.push_back(B_ACK);
        send_wr_frame(8'h01, 8'h02);
        drain("after_timeout");
    endtask

    task automatic test_error_hold;
        int n = 0;
        int w0;
        w0 = wr_count;
        bif.to_uart_ready = 1'b0;
        exp_rsp.push_back(B_NAK);
        send_byte(B_WR, 1'b0);
        send_byte(8'h10, 1'b1);
        while (!bif.to_uart_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bif.to_uart_valid !== 1'b1 || bif.to_uart_data !== B_NAK) begin
                errors++;
                $display("FAIL hold_stable got valid=%b data=%02h exp valid=1 data=%02h",
                         bif.to_uart_valid, bif.to_uart_data, B_NAK);
            end
        end
        bif.to_uart_ready = 1'b1;
        drain("error_hold");
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL error_no_wr got %0d exp 0", wr_count - w0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            exp_wr.push_back({a, d});
            exp_rsp.push_back(B_ACK);
            send_wr_frame(a, d);
            if (i == 3) begin
                exp_rsp.push_back(B_NAK);
                send_byte(8'h00, 1'b0);
            end
        end
        drain("back_to_back");
    endtask

`ifdef UART_BRIDGE_CHKSUM_EN
    task automatic test_checksum;
        int w0;
        exp_wr.push_back({8'h10, 8'h3C});
        exp_rsp.push_back(B_ACK);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h89, 1'b0);
        drain("csum_good");
        w0 = wr_count;
        exp_rsp.push_back(B_NAK);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h00, 1'b0);
        drain("csum_bad");
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL csum_bad_no_wr got %0d exp 0", wr_count - w0);
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int n = 0;
        send_byte(B_WR, 1'b0);
        send_byte(8'h10, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_frame");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // Abort a response that is still waiting for the transmitter
        bif.to_uart_ready = 1'b0;
        send_byte(8'h77, 1'b0);
        while (!bif.to_uart_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_send");
        repeat (3) @(negedge clk);
        bif.to_uart_ready = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        exp_wr.push_back({8'h44, 8'h33});
        exp_rsp.push_back(B_ACK);
        send_wr_frame(8'h44, 8'h33);
        drain("after_reset");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_count = 0;
        rd_count = 0;
        prev_wr  = 1'b0;
        prev_rd  = 1'b0;
        reset    = 1'b0;
        bif.from_uart_data  = 8'h00;
        bif.from_uart_error = 1'b0;
        bif.from_uart_valid = 1'b0;
        bif.to_uart_ready   = 1'b1;
        bif.reg_rdata       = 8'h00;
        bif.reg_rdvalid     = 1'b0;

        test_reset;
        test_write;
        test_read;
        test_read_timeout;
        test_bad_cmd;
        test_byte_timeout;
        test_error_hold;
        test_back_to_back;
`ifdef UART_BRIDGE_CHKSUM_EN
        test_checksum;
`endif
        test_reset_mid_frame;

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
